// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: extracts and extends big-endian load data,
// stalls upstream on slow dmem with a bounded wait, flags misaligned and timed-out loads.
module mem_wb_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_link_pc,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic        mem_is_load,
  input  logic [1:0]  mem_load_size,
  input  logic        mem_load_unsigned,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_link_pc,
  output logic [1:0]  wb_sel,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_misaligned,
  output logic        wb_bus_error
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  logic [1:0]  off;
  logic        word_sz;
  logic        mis;
  logic        aligned_ld;
  logic        timed_out;
  logic        retire;
  logic        berr;
  logic        sx;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;

  always_comb begin
    off        = mem_alu_result[1:0];
    word_sz    = (mem_load_size == 2'b00) || (mem_load_size == 2'b11);
    mis        = mem_is_load &&
                 (word_sz ? (off != 2'b00)
                          : ((mem_load_size == 2'b01) && off[0]));
    aligned_ld = mem_valid && mem_is_load && !mis;
    timed_out  = (MEM_TIMEOUT != 0) && (cnt == TO);
  end

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    byte_v = dmem_rdata[31:24];
    unique case (off)
      2'd0: byte_v = dmem_rdata[31:24];
      2'd1: byte_v = dmem_rdata[23:16];
      2'd2: byte_v = dmem_rdata[15:8];
      2'd3: byte_v = dmem_rdata[7:0];
    endcase
    half_v = off[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    sx     = 1'b0;
    unique case (mem_load_size)
      2'b10: begin
        sx      = !mem_load_unsigned && byte_v[7];
        ld_data = {{24{sx}}, byte_v};
      end
      2'b01: begin
        sx      = !mem_load_unsigned && half_v[15];
        ld_data = {{16{sx}}, half_v};
      end
      default: ld_data = dmem_rdata;
    endcase
  end

  // WAIT retires the held load regardless of mem_valid: upstream is
  // frozen by the stall, so the load is still the MEM instruction.
  always_comb begin
    retire  = 1'b0;
    berr    = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    if (flush) begin
      state_n = S_RUN;
      cnt_n   = '0;
    end else if (state == S_RUN) begin
      if (aligned_ld && !dmem_ready) begin
        state_n = S_WAIT;
        cnt_n   = CW'(1);
      end else begin
        retire = mem_valid;
      end
    end else if (dmem_ready || timed_out) begin
      retire  = 1'b1;
      berr    = !dmem_ready;
      state_n = S_RUN;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  assign mem_stall = !rst && (state_n == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      cnt           <= '0;
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_link_pc    <= '0;
      wb_sel        <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_bus_error  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      wb_valid      <= retire;
      wb_alu_result <= retire ? mem_alu_result : '0;
      wb_link_pc    <= retire ? mem_link_pc : '0;
      wb_sel        <= retire ? mem_wb_sel : '0;
      wb_rd         <= retire ? mem_rd : '0;
      wb_mem_data   <= (retire && mem_is_load && !mis && !berr)
                       ? ld_data : '0;
      wb_reg_write  <= retire && mem_reg_write && !mis && !berr;
      wb_misaligned <= retire && mis;
      wb_bus_error  <= retire && berr;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed table, stall/flush/reset
// sequences and randomized transactions against a transaction-level model.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_link_pc;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic        mem_is_load;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_link_pc;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_misaligned;
  logic        wb_bus_error;

  mem_wb_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result),
    .mem_link_pc(mem_link_pc),
    .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel),
    .mem_is_load(mem_is_load),
    .mem_load_size(mem_load_size),
    .mem_load_unsigned(mem_load_unsigned),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_stall(mem_stall),
    .wb_valid(wb_valid),
    .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data),
    .wb_link_pc(wb_link_pc),
    .wb_sel(wb_sel),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .wb_misaligned(wb_misaligned),
    .wb_bus_error(wb_bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] link;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] rdata;
  } txn_t;

  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [31:0] md;
    logic [31:0] link;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        be;
  } wb_t;

  typedef struct {
    string       nm;
    txn_t        t;
    bit          rdy;
    logic [31:0] md;
    bit          rw;
    bit          mis;
  } vec_t;

  localparam wb_t BUB = '0;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic txn_t mk(logic [31:0] alu, logic [4:0] rd,
                              logic rw, logic [1:0] sel, logic ld,
                              logic [1:0] sz, logic uns,
                              logic [31:0] rdata);
    txn_t t;
    t.alu = alu; t.link = ~alu; t.rd = rd; t.rw = rw;
    t.sel = sel; t.ld = ld; t.sz = sz; t.uns = uns;
    t.rdata = rdata;
    return t;
  endfunction

  function automatic bit misal(txn_t t);
    int off;
    off = int'(t.alu % 4);
    if (!t.ld) return 0;
    if (t.sz == 2'd1) return (off % 2) != 0;
    if (t.sz == 2'd2) return 0;
    return off != 0;
  endfunction

  function automatic wb_t model(txn_t t, bit berr);
    wb_t r;
    int off;
    longint x;
    bit mis;
    off = int'(t.alu % 4);
    mis = misal(t);
    r = '0;
    r.v = 1'b1; r.alu = t.alu; r.link = t.link;
    r.sel = t.sel; r.rd = t.rd;
    r.mis = mis; r.be = berr;
    r.rw = t.rw && !mis && !berr;
    if (t.ld && !mis && !berr) begin
      if (t.sz == 2'd2) begin
        x = longint'((t.rdata >> (8 * (3 - off))) & 32'hFF);
        if (!t.uns && x >= 128) x = x - 256;
      end else if (t.sz == 2'd1) begin
        x = longint'((t.rdata >> (16 * (1 - off / 2))) & 32'hFFFF);
        if (!t.uns && x >= 32768) x = x - 65536;
      end else begin
        x = longint'(t.rdata);
      end
      r.md = x[31:0];
    end
    return r;
  endfunction

  function automatic wb_t ex(txn_t t, logic [31:0] md, bit rw, bit mis);
    wb_t r;
    r = '0;
    r.v = 1'b1; r.alu = t.alu; r.link = t.link;
    r.sel = t.sel; r.rd = t.rd;
    r.md = md; r.rw = rw; r.mis = mis;
    return r;
  endfunction

  task automatic chk_stall(string nm, logic e);
    n_vec++;
    if (mem_stall !== e) begin
      n_err++;
      $display("FAIL %s: mem_stall=%b want %b", nm, mem_stall, e);
    end
  endtask

  task automatic chk_wb(string nm, wb_t e);
    wb_t a;
    a = {wb_valid, wb_alu_result, wb_mem_data, wb_link_pc, wb_sel,
         wb_rd, wb_reg_write, wb_misaligned, wb_bus_error};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: wb=%h want %h", nm, a, e);
    end
  endtask

  task automatic drive(txn_t t, bit v);
    mem_valid = v;
    mem_alu_result = t.alu;
    mem_link_pc = t.link;
    mem_rd = t.rd;
    mem_reg_write = t.rw;
    mem_wb_sel = t.sel;
    mem_is_load = t.ld;
    mem_load_size = t.sz;
    mem_load_unsigned = t.uns;
    dmem_rdata = t.rdata;
  endtask

  // d = cycles dmem_ready stays low before rising.
  task automatic do_txn(string nm, txn_t t, bit v, int d);
    int nst;
    bit al;
    al = v && t.ld && !misal(t);
    nst = al ? ((d < TO) ? d : TO) : 0;
    drive(t, v);
    for (int i = 0; i <= nst; i++) begin
      dmem_ready = (i >= d);
      #1;
      chk_stall(nm, i < nst);
      @(posedge clk); #1;
      if (i < nst) chk_wb(nm, BUB);
      else chk_wb(nm, v ? model(t, al && d > TO) : BUB);
    end
    mem_valid = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic add(string nm, txn_t t, bit rdy, logic [31:0] md,
                     bit rw, bit mis);
    vec_t v;
    v.nm = nm; v.t = t; v.rdy = rdy; v.md = md; v.rw = rw; v.mis = mis;
    tbl.push_back(v);
  endtask

  initial begin
    txn_t t;
    logic [31:0] rd0;
    rd0 = 32'h8899AABB;
    rst = 1'b1;
    flush = 1'b0;
    dmem_ready = 1'b0;
    drive('0, 1'b0);
    @(posedge clk); #1;
    chk_stall("reset_stall", 1'b0);
    chk_wb("reset_wb", BUB);
    rst = 1'b0;

    add("lb_s",    mk(32'h1001, 5, 1, 1, 1, 2, 0, rd0), 1, 32'hFFFFFF99, 1, 0);
    add("lbu",     mk(32'h1001, 5, 1, 1, 1, 2, 1, rd0), 1, 32'h00000099, 1, 0);
    add("lh_s2",   mk(32'h1002, 6, 1, 1, 1, 1, 0, rd0), 1, 32'hFFFFAABB, 1, 0);
    add("lhu2",    mk(32'h1002, 6, 1, 1, 1, 1, 1, rd0), 1, 32'h0000AABB, 1, 0);
    add("lw_mis",  mk(32'h1002, 7, 1, 1, 1, 0, 0, rd0), 0, 32'h0, 0, 1);
    add("lw",      mk(32'h1000, 7, 1, 1, 1, 0, 0, rd0), 1, 32'h8899AABB, 1, 0);
    add("lbu3",    mk(32'h1003, 8, 1, 1, 1, 2, 1, rd0), 1, 32'h000000BB, 1, 0);
    add("lb_s0",   mk(32'h1000, 8, 1, 1, 1, 2, 0, rd0), 1, 32'hFFFFFF88, 1, 0);
    add("lb_s2",   mk(32'h1002, 8, 1, 1, 1, 2, 0, rd0), 1, 32'hFFFFFFAA, 1, 0);
    add("lh_s0",   mk(32'h1000, 9, 1, 1, 1, 1, 0, rd0), 1, 32'hFFFF8899, 1, 0);
    add("lh_mis",  mk(32'h1001, 9, 1, 1, 1, 1, 0, rd0), 0, 32'h0, 0, 1);
    add("lw_sz3",  mk(32'h1000, 9, 1, 1, 1, 3, 0, rd0), 1, 32'h8899AABB, 1, 0);
    add("sz3_mis", mk(32'h1001, 9, 1, 1, 1, 3, 0, rd0), 0, 32'h0, 0, 1);
    add("alu_rd0", mk(32'hDEADBEEF, 0, 1, 0, 0, 0, 0, rd0), 0, 32'h0, 1, 0);
    add("link",    mk(32'h00400010, 31, 1, 2, 0, 0, 0, rd0), 0, 32'h0, 1, 0);
    add("nowrite", mk(32'h12345678, 3, 0, 3, 0, 0, 0, rd0), 1, 32'h0, 0, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].t, 1'b1);
      dmem_ready = tbl[k].rdy;
      #1;
      chk_stall(tbl[k].nm, 1'b0);
      @(posedge clk); #1;
      chk_wb(tbl[k].nm, ex(tbl[k].t, tbl[k].md, tbl[k].rw, tbl[k].mis));
    end
    mem_valid = 1'b0;

    // Slow memory, ready after 3 low cycles.
    t = mk(32'h2000, 10, 1, 1, 1, 0, 0, 32'hCAFEF00D);
    do_txn("slow_lw", t, 1'b1, 3);
    do_txn("after_mis", mk(32'h2003, 4, 1, 1, 1, 0, 0, 32'h1), 1'b1, 5);
    do_txn("bubble", t, 1'b0, 0);

    // Timeout: ready never rises, next instruction proceeds.
    do_txn("timeout", t, 1'b1, 100);
    do_txn("post_to", mk(32'h55, 2, 1, 0, 0, 0, 0, 32'h0), 1'b1, 0);
    do_txn("edge_to", t, 1'b1, TO);

    // Flush at cnt=2, then a late ready.
    drive(t, 1'b1);
    dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; chk_stall("fl_wait", 1'b1);
      @(posedge clk); #1; chk_wb("fl_wait", BUB);
    end
    flush = 1'b1;
    #1; chk_stall("fl_cyc", 1'b0);
    @(posedge clk); #1; chk_wb("fl_cyc", BUB);
    flush = 1'b0;
    mem_valid = 1'b0;
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; chk_stall("fl_late", 1'b0);
      @(posedge clk); #1; chk_wb("fl_late", BUB);
    end
    dmem_ready = 1'b0;

    // Reset at cnt=3, then FSM must restart from RUN.
    drive(t, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1; chk_stall("rw_wait", 1'b1);
      @(posedge clk); #1; chk_wb("rw_wait", BUB);
    end
    rst = 1'b1;
    #1; chk_stall("rw_rst", 1'b0);
    @(posedge clk); #1; chk_wb("rw_rst", BUB);
    rst = 1'b0;
    mem_valid = 1'b0;
    #1; chk_stall("rw_idle", 1'b0);
    do_txn("rw_full", t, 1'b1, 100);

    for (int n = 0; n < 300; n++) begin
      t.alu = $urandom;
      t.link = $urandom;
      t.rd = 5'($urandom);
      t.rw = 1'($urandom);
      t.sel = 2'($urandom);
      t.ld = ($urandom_range(0, 9) < 6);
      t.sz = 2'($urandom);
      t.uns = 1'($urandom);
      t.rdata = $urandom;
      do_txn("rand", t, $urandom_range(0, 9) != 0, $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
